// File: rtl/cdb_arbiter.sv
// Writeback arbiter: five one-entry FU holding slots, granted round-robin one per
// cycle onto a registered common data bus feeding the ROB and reservation stations.
module cdb_arbiter #(
    parameter int NUM_FU = 5,
    parameter int XLEN   = 32,
    parameter int ROB_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [NUM_FU-1:0]       fu_valid,
    input  logic [NUM_FU*XLEN-1:0]  fu_result,
    input  logic [NUM_FU*ROB_W-1:0] fu_rob_entry,
    output logic [NUM_FU-1:0]       fu_ready,
    output logic                    cdb_valid,
    output logic [XLEN-1:0]         cdb_value,
    output logic [ROB_W-1:0]        cdb_rob_entry,
    output logic [2:0]              cdb_fu_id
);

    localparam int ID_W = 3;
    localparam int PW   = ID_W + 1;

    logic [NUM_FU-1:0] r_occ;
    logic [XLEN-1:0]   r_data [NUM_FU];
    logic [ROB_W-1:0]  r_tag  [NUM_FU];
    logic [ID_W-1:0]   r_rr_ptr;
    logic              r_cdb_valid;
    logic [XLEN-1:0]   r_cdb_value;
    logic [ROB_W-1:0]  r_cdb_rob_entry;
    logic [ID_W-1:0]   r_cdb_fu_id;

    logic              w_grant_vld;
    logic [ID_W-1:0]   w_grant_idx;
    logic [PW-1:0]     w_probe;
    logic [NUM_FU-1:0] w_grant;
    logic [NUM_FU-1:0] w_push;
    logic [ID_W-1:0]   w_rr_next;

    // Round-robin search over occupied slots starting at r_rr_ptr; fu_valid never participates.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = {ID_W{1'b0}};
        w_probe     = {PW{1'b0}};
        for (int k = 0; k < NUM_FU; k++) begin
            w_probe = {1'b0, r_rr_ptr} + PW'(k);
            if (w_probe >= PW'(NUM_FU)) begin
                w_probe = w_probe - PW'(NUM_FU);
            end else begin
                w_probe = w_probe;
            end
            if (!w_grant_vld && r_occ[w_probe[ID_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_probe[ID_W-1:0];
            end else begin
                w_grant_vld = w_grant_vld;
            end
        end
    end

    // One-hot grant vector and the pointer value that follows it.
    always_comb begin
        w_grant = {NUM_FU{1'b0}};
        if (w_grant_vld) begin
            w_grant[w_grant_idx] = 1'b1;
        end else begin
            w_grant = {NUM_FU{1'b0}};
        end
        if (w_grant_idx == ID_W'(NUM_FU - 1)) begin
            w_rr_next = {ID_W{1'b0}};
        end else begin
            w_rr_next = w_grant_idx + ID_W'(1);
        end
    end

    // A slot granted this cycle can be refilled on the same edge.
    assign fu_ready = ~r_occ | w_grant;
    assign w_push   = fu_valid & fu_ready;

    // Holding slots: load on push, release on grant, everything squashed on flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_occ <= {NUM_FU{1'b0}};
            for (int i = 0; i < NUM_FU; i++) begin
                r_data[i] <= {XLEN{1'b0}};
                r_tag[i]  <= {ROB_W{1'b0}};
            end
        end else if (flush) begin
            r_occ <= {NUM_FU{1'b0}};
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_push[i]) begin
                    r_occ[i]  <= 1'b1;
                    r_data[i] <= fu_result[i*XLEN +: XLEN];
                    r_tag[i]  <= fu_rob_entry[i*ROB_W +: ROB_W];
                end else if (w_grant[i]) begin
                    r_occ[i] <= 1'b0;
                end
            end
        end
    end

    // Registered CDB and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr        <= {ID_W{1'b0}};
            r_cdb_valid     <= 1'b0;
            r_cdb_value     <= {XLEN{1'b0}};
            r_cdb_rob_entry <= {ROB_W{1'b0}};
            r_cdb_fu_id     <= {ID_W{1'b0}};
        end else if (flush) begin
            r_rr_ptr    <= {ID_W{1'b0}};
            r_cdb_valid <= 1'b0;
        end else if (w_grant_vld) begin
            r_rr_ptr        <= w_rr_next;
            r_cdb_valid     <= 1'b1;
            r_cdb_value     <= r_data[w_grant_idx];
            r_cdb_rob_entry <= r_tag[w_grant_idx];
            r_cdb_fu_id     <= w_grant_idx;
        end else begin
            r_cdb_valid <= 1'b0;
        end
    end

    assign cdb_valid     = r_cdb_valid;
    assign cdb_value     = r_cdb_value;
    assign cdb_rob_entry = r_cdb_rob_entry;
    assign cdb_fu_id     = r_cdb_fu_id;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a slot-level reference model predicts every CDB
// broadcast and its cycle; an independent monitor pops and compares on cdb_valid.
module tb_cdb_arbiter;

    logic         clk;
    logic         reset;
    logic         flush;
    logic [4:0]   fu_valid;
    logic [159:0] fu_result;
    logic [19:0]  fu_rob_entry;
    logic [4:0]   fu_ready;
    logic         cdb_valid;
    logic [31:0]  cdb_value;
    logic [3:0]   cdb_rob_entry;
    logic [2:0]   cdb_fu_id;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] v;
        logic [3:0]  t;
        logic [2:0]  id;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    logic        m_occ  [5];
    logic [31:0] m_data [5];
    logic [3:0]  m_tag  [5];
    int          m_rr;

    logic [4:0]  hold;
    logic [4:0]  dir_en;
    logic [31:0] dir_data [5];
    logic [3:0]  dir_tag  [5];

    cdb_arbiter #(.NUM_FU(5), .XLEN(32), .ROB_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .fu_valid      (fu_valid),
        .fu_result     (fu_result),
        .fu_rob_entry  (fu_rob_entry),
        .fu_ready      (fu_ready),
        .cdb_valid     (cdb_valid),
        .cdb_value     (cdb_value),
        .cdb_rob_entry (cdb_rob_entry),
        .cdb_fu_id     (cdb_fu_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 5; i++) begin
            m_occ[i]  = 1'b0;
            m_data[i] = 32'h0;
            m_tag[i]  = 4'h0;
        end
        m_rr = 0;
    endtask

    // First occupied slot scanning rr, rr+1, ... modulo five; -1 when all empty.
    function automatic int model_grant();
        for (int k = 0; k < 5; k++) begin
            if (m_occ[(m_rr + k) % 5]) return (m_rr + k) % 5;
        end
        return -1;
    endfunction

    task automatic dir_push(input int fu, input logic [31:0] d, input logic [3:0] t);
        dir_en[fu]   = 1'b1;
        dir_data[fu] = d;
        dir_tag[fu]  = t;
    endtask

    // Called at a falling edge: drive inputs for the next rising edge and advance the model.
    task automatic drive_cycle(input logic [4:0] want, input logic fl);
        int         g;
        logic [4:0] mr;
        for (int i = 0; i < 5; i++) begin
            if (!hold[i]) begin
                fu_valid[i] = want[i];
                if (want[i]) begin
                    fu_result[i*32 +: 32]  = dir_en[i] ? dir_data[i] : $urandom;
                    fu_rob_entry[i*4 +: 4] = dir_en[i] ? dir_tag[i] : 4'($urandom);
                end
            end
        end
        dir_en = 5'b0;
        flush  = fl;
        g = model_grant();
        for (int i = 0; i < 5; i++) mr[i] = !m_occ[i] || (g == i);
        #1;
        chk("fu_ready", {59'b0, fu_ready}, {59'b0, mr});
        if (fl) begin
            model_clear();
            hold = 5'b0;
        end else begin
            if (g >= 0) begin
                exp_q.push_back('{m_data[g], m_tag[g], 3'(g), cyc + 1});
                m_occ[g] = 1'b0;
                m_rr     = (g + 1) % 5;
            end
            for (int i = 0; i < 5; i++) begin
                if (fu_valid[i] && mr[i]) begin
                    m_occ[i]  = 1'b1;
                    m_data[i] = fu_result[i*32 +: 32];
                    m_tag[i]  = fu_rob_entry[i*4 +: 4];
                end
                hold[i] = fu_valid[i] && !mr[i];
            end
        end
        @(negedge clk);
    endtask

    task automatic async_reset_check();
        #2 reset = 1'b0;
        #1;
        chk("rst_cdb_valid", {63'b0, cdb_valid}, 64'd0);
        chk("rst_cdb_value", {32'b0, cdb_value}, 64'd0);
        chk("rst_cdb_tag", {60'b0, cdb_rob_entry}, 64'd0);
        chk("rst_cdb_id", {61'b0, cdb_fu_id}, 64'd0);
        chk("rst_fu_ready", {59'b0, fu_ready}, 64'h1f);
        fu_valid = 5'b0;
        flush    = 1'b0;
        hold     = 5'b0;
        model_clear();
        exp_q.delete();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: every CDB broadcast must match the oldest prediction, in its predicted cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            if (cdb_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL cdb_unexpected: got v=%h t=%h id=%0d at cyc=%0d expected no broadcast",
                             cdb_value, cdb_rob_entry, cdb_fu_id, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cdb_value !== e.v || cdb_rob_entry !== e.t || cdb_fu_id !== e.id || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL cdb_out: got v=%h t=%h id=%0d cyc=%0d expected v=%h t=%h id=%0d cyc=%0d",
                                 cdb_value, cdb_rob_entry, cdb_fu_id, cyc, e.v, e.t, e.id, e.cyc);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                checks++;
                failures++;
                e = exp_q.pop_front();
                $display("FAIL cdb_missing: got cdb_valid=0 at cyc=%0d expected v=%h t=%h id=%0d",
                         cyc, e.v, e.t, e.id);
            end
        end
    end

    initial begin
        reset        = 1'b0;
        flush        = 1'b0;
        fu_valid     = 5'b0;
        fu_result    = 160'b0;
        fu_rob_entry = 20'b0;
        hold         = 5'b0;
        dir_en       = 5'b0;
        model_clear();
        #1;
        chk("init_cdb_valid", {63'b0, cdb_valid}, 64'd0);
        chk("init_cdb_value", {32'b0, cdb_value}, 64'd0);
        chk("init_cdb_id", {61'b0, cdb_fu_id}, 64'd0);
        chk("init_fu_ready", {59'b0, fu_ready}, 64'h1f);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);

        // Single push from the multiplier, then FU0+FU4 together with the pointer at 3.
        dir_push(2, 32'hDEADBEEF, 4'd7);
        drive_cycle(5'b00100, 1'b0);
        repeat (2) drive_cycle(5'b00000, 1'b0);
        drive_cycle(5'b10001, 1'b0);
        repeat (3) drive_cycle(5'b00000, 1'b0);

        // Flush returns the pointer to 0, then all five push on one edge.
        drive_cycle(5'b00000, 1'b1);
        drive_cycle(5'b11111, 1'b0);
        repeat (6) drive_cycle(5'b00000, 1'b0);

        // FU0 streams, FU1 pushes twice back-to-back, FU3 pushes once.
        drive_cycle(5'b01011, 1'b0);
        drive_cycle(5'b00011, 1'b0);
        repeat (8) drive_cycle(5'b00001, 1'b0);
        repeat (6) drive_cycle(5'b00000, 1'b0);

        // Flush with three slots occupied and the CDB busy while FU4 pushes.
        drive_cycle(5'b01111, 1'b0);
        drive_cycle(5'b00000, 1'b0);
        dir_push(4, 32'hF1F1F1F1, 4'hF);
        drive_cycle(5'b10000, 1'b1);
        chk("flush_cdb_valid", {63'b0, cdb_valid}, 64'd0);
        repeat (3) drive_cycle(5'b00000, 1'b0);

        // Asynchronous reset mid-stream, then the first push after release.
        drive_cycle(5'b11111, 1'b0);
        drive_cycle(5'b00110, 1'b0);
        async_reset_check();
        dir_push(0, 32'h1, 4'd1);
        drive_cycle(5'b00001, 1'b0);
        repeat (3) drive_cycle(5'b00000, 1'b0);

        // Randomised traffic with occasional flushes and resets.
        for (int n = 0; n < 1500; n++) begin
            if (n % 500 == 250) async_reset_check();
            drive_cycle(5'($urandom), $urandom_range(0, 39) == 0);
        end
        repeat (10) drive_cycle(5'b00000, 1'b0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Writeback arbiter for the execute stage: collects completed results from the five functional units (two ALUs, multiplier, divider, shifter) and serialises them onto the single common data bus (CDB) that feeds the ROB and the reservation stations. Each FU owns a one-entry holding slot. Occupied slots are granted round-robin, one per cycle, into a registered CDB output. A per-FU ready handshake back-pressures an FU whose slot is still waiting.

## Interface
- NUM_FU, 5, number of functional units; slot i serves FU i: 0=ALU0, 1=ALU1, 2=MUL, 3=DIV, 4=SHIFT
- XLEN, 32, result width
- ROB_W, 4, ROB entry tag width
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash (mispredict); clears all slots and the CDB register
- fu_valid  in  NUM_FU  FU i presents a result this cycle
- fu_result  in  NUM_FU*XLEN  result of FU i at bits [i*XLEN +: XLEN]
- fu_rob_entry  in  NUM_FU*ROB_W  ROB tag of FU i at bits [i*ROB_W +: ROB_W]
- fu_ready  out  NUM_FU  slot i can accept a result this cycle; a transfer occurs when fu_valid[i] & fu_ready[i]
- cdb_valid  out  1  CDB carries a result this cycle
- cdb_value  out  XLEN  broadcast result
- cdb_rob_entry  out  ROB_W  broadcast ROB tag
- cdb_fu_id  out  3  index of the FU that produced the broadcast result

## Operation
- Per slot state: occ[i], data[i], tag[i].
- Push: on an edge with fu_valid[i] & fu_ready[i] & ~flush, data[i] and tag[i] load and occ[i] is set.
- fu_ready[i] = ~occ[i] | grant[i]. The combinational path from grant to fu_ready is intentional: a slot granted this cycle accepts a new result on the same edge.
- An FU seeing fu_ready[i]=0 must hold fu_valid and data stable. The arbiter never drops a presented result except on flush or reset.
- Arbitration, combinational from registered state only:
  - grant = first i with occ[i] set, searching rr_ptr, rr_ptr+1, … mod NUM_FU.
  - At most one grant per cycle.
  - fu_valid does not participate; there is no input bypass.
- On an edge with a grant:
  - cdb_value, cdb_rob_entry and cdb_fu_id load from the granted slot; cdb_valid is set.
  - occ[grant] clears, unless the same edge pushes a new result into that slot.
  - rr_ptr loads (grant+1) mod NUM_FU, wrapping 4→0.
- On an edge with no grant: cdb_valid clears, cdb data fields hold, rr_ptr holds.
- flush (synchronous, highest priority after reset):
  - next edge clears every occ bit and cdb_valid and resets rr_ptr to 0;
  - pushes and grants in the flush cycle are discarded.
- reset low (asynchronous):
  - occ=0, rr_ptr=0, cdb_valid=0, cdb_value=0, cdb_rob_entry=0, cdb_fu_id=0;
  - therefore fu_ready=all ones while in reset.
  - Takes effect immediately, mid-transfer included; the first push is accepted on the first edge after reset rises.

## Timing
- Latency: a result pushed on edge E0 is granted at the earliest in the following cycle and appears on the CDB from edge E1 for exactly one cycle (cdb_valid high in the cycle after E1).
- Throughput: one CDB result per cycle while any slot is occupied; per FU, one result per cycle sustained when its slot is granted every time.
- Worst-case wait for an occupied slot: NUM_FU-1 = 4 grants to other slots, then its own. No starvation.
- cdb_valid pulses high for one cycle per granted result; back-to-back results keep it high continuously.
- fu_ready depends combinationally on registered state only. No path from fu_valid to fu_ready.

## Test plan
- Reset: hold reset low mid-stream with slots occupied → all outputs 0 and fu_ready=5'b11111 immediately; after release, push FU0 0x1 tag 1 → CDB 0x1/tag 1/id 0 one cycle later.
- Single push: FU2 pushes 0xDEADBEEF tag 7 on E0 → after E1, cdb_valid=1, value 0xDEADBEEF, tag 7, fu_id 2 for exactly one cycle; rr_ptr=3.
- All-five burst: all FUs push distinct values on the same edge with rr_ptr=0 → CDB fu_id sequence 0,1,2,3,4 on five consecutive cycles; cdb_valid continuously high; rr_ptr ends at 0 (wrap).
- Fairness and back-pressure: FU0 pushes every cycle while FU3 pushes once and FU1 pushes twice back-to-back.
  - FU1's second push waits with fu_ready[1]=0 until its slot is granted.
  - FU3 is granted within 5 cycles of its push despite FU0 streaming.
  - Same-edge grant-and-refill of slot 0 occurs with no lost result.
- Flush: three slots occupied and cdb_valid=1; assert flush for one cycle while FU4 pushes → next cycle cdb_valid=0, occ=0, fu_ready=all ones, rr_ptr=0, and FU4's value never appears on the CDB.
